// File: rtl/mesm6_intctl.sv
// mesm6_intctl: priority interrupt controller for the MESM-6 core.
// Rising edges on irq_in become pending bits. Pending bits are masked by
// IEN and GIE, and the lowest-index request goes to the core. The ISR
// register tracks nested service levels: an ack sets ISR and an EOI write
// clears it. Register-mapped on the 48-bit peripheral bus.
module mesm6_intctl #(
  parameter int NIRQ = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq_in,
  output logic            cpu_irq,
  output logic [3:0]      cpu_vec,
  input  logic            cpu_ack,
  input  logic [14:0]     ic_addr,
  input  logic            ic_read,
  input  logic            ic_write,
  output logic [47:0]     ic_rdata,
  input  logic [47:0]     ic_wdata,
  output logic            ic_done
);

  typedef enum logic [2:0] {
    A_PEND = 3'd0,
    A_IEN  = 3'd1,
    A_ISR  = 3'd2,
    A_EOI  = 3'd3,
    A_GIE  = 3'd4,
    A_VEC  = 3'd5
  } reg_addr_e;

  logic [NIRQ-1:0] irq_q, irq_d;
  logic [NIRQ-1:0] pend_q, pend_d;
  logic [NIRQ-1:0] ien_q, ien_d;
  logic [NIRQ-1:0] isr_q, isr_d;
  logic            gie_q, gie_d;
  logic            done_q, done_d;

  logic [NIRQ-1:0] req;
  logic [NIRQ-1:0] rise;
  logic [3:0]      w;      // winning request index
  logic [4:0]      s;      // lowest in-service index, NIRQ when idle
  logic            take;

  // Address bits above [2:0] and the unused write-data bits are ignored.
  logic unused_bits;
  assign unused_bits = ^{ic_addr[14:3], ic_wdata[47:NIRQ]};

  // Priority resolution: pick the winning request and the current service level.
  always_comb begin
    // NOTE: every signal gets a default before any conditional update, so no latches are inferred.
    req  = pend_q & ien_q;
    rise = irq_in & ~irq_q;
    w    = '0;
    s    = 5'(NIRQ);
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (req[i])   w = 4'(i);
      if (isr_q[i]) s = 5'(i);
    end
    cpu_irq = gie_q & (|req) & ({1'b0, w} < s);
    cpu_vec = cpu_irq ? w : 4'd0;
    take    = cpu_ack & cpu_irq;
  end

  // Next-state logic: bus writes, then ack, then edge capture (the rise wins).
  always_comb begin
    irq_d  = irq_in;
    pend_d = pend_q;
    ien_d  = ien_q;
    isr_d  = isr_q;
    gie_d  = gie_q;
    done_d = ic_read | ic_write;
    if (ic_write) begin
      case (ic_addr[2:0])
        A_PEND: pend_d = pend_q & ~ic_wdata[NIRQ-1:0];
        A_IEN:  ien_d  = ic_wdata[NIRQ-1:0];
        A_EOI: begin
          // The EOI target comes from the ISR value before the edge.
          for (int i = 0; i < NIRQ; i++)
            if (i == int'(s)) isr_d[i] = 1'b0;
        end
        A_GIE:  gie_d  = ic_wdata[0];
        default: ;
      endcase
    end
    // The ack set comes after the EOI clear, so both take effect.
    for (int i = 0; i < NIRQ; i++) begin
      if (take && i == int'(w)) begin
        pend_d[i] = 1'b0;
        isr_d[i]  = 1'b1;
      end
    end
    pend_d = pend_d | rise;
  end

  // Combinational read mux; unmapped bits and addresses read as zero.
  always_comb begin
    ic_rdata = '0;
    case (ic_addr[2:0])
      A_PEND: ic_rdata[NIRQ-1:0] = pend_q;
      A_IEN:  ic_rdata[NIRQ-1:0] = ien_q;
      A_ISR:  ic_rdata[NIRQ-1:0] = isr_q;
      A_GIE:  ic_rdata[0]        = gie_q;
      A_VEC:  ic_rdata           = {cpu_irq, 43'b0, cpu_vec};
      default: ;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments, so every flop samples the values from before the edge.
    if (reset) begin
      irq_q  <= '0;
      pend_q <= '0;
      ien_q  <= '0;
      isr_q  <= '0;
      gie_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      irq_q  <= irq_d;
      pend_q <= pend_d;
      ien_q  <= ien_d;
      isr_q  <= isr_d;
      gie_q  <= gie_d;
      done_q <= done_d;
    end
  end

  assign ic_done = done_q;

endmodule

// File: tb/tb_mesm6_intctl.sv
// tb_mesm6_intctl: directed and randomized test of mesm6_intctl.
// The reference model keeps the register state as integers. It derives
// priorities from bit arithmetic (lowest set bit = clog2(x & -x)).
module tb_mesm6_intctl;
  localparam int NIRQ = 8;
  localparam int MASK = (1 << NIRQ) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [NIRQ-1:0] irq_in;
  logic            cpu_irq;
  logic [3:0]      cpu_vec;
  logic            cpu_ack;
  logic [14:0]     ic_addr;
  logic            ic_read;
  logic            ic_write;
  logic [47:0]     ic_rdata;
  logic [47:0]     ic_wdata;
  logic            ic_done;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  int m_pend = 0, m_ien = 0, m_isr = 0, m_gie = 0, m_irqq = 0, m_done = 0;

  mesm6_intctl #(.NIRQ(NIRQ)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in),
    .cpu_irq(cpu_irq), .cpu_vec(cpu_vec), .cpu_ack(cpu_ack),
    .ic_addr(ic_addr), .ic_read(ic_read), .ic_write(ic_write),
    .ic_rdata(ic_rdata), .ic_wdata(ic_wdata), .ic_done(ic_done)
  );

  always #5 clk = ~clk;

  function automatic int lowest(int x);
    if (x == 0) return NIRQ;
    return $clog2(x & -x);
  endfunction

  function automatic int exp_irq();
    int r = m_pend & m_ien;
    return (m_gie != 0 && r != 0 && lowest(r) < lowest(m_isr)) ? 1 : 0;
  endfunction

  function automatic int exp_vec();
    return exp_irq() != 0 ? lowest(m_pend & m_ien) : 0;
  endfunction

  function automatic logic [47:0] m_read(int a);
    logic [47:0] v = '0;
    case (a)
      0: v = 48'(m_pend);
      1: v = 48'(m_ien);
      2: v = 48'(m_isr);
      4: v = 48'(m_gie);
      5: begin v[47] = 1'(exp_irq()); v[3:0] = 4'(exp_vec()); end
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock: compute the model's next state from the applied
  // inputs, step past the edge and compare every visible output.
  task automatic tick();
    int np, ni, nie, ng, nq, nd, rise, w, wd;
    bit take;
    wd = int'(ic_wdata[15:0]) & MASK;
    nd = (ic_read || ic_write) ? 1 : 0;
    if (reset) begin
      np = 0; ni = 0; nie = 0; ng = 0; nq = 0; nd = 0;
    end else begin
      rise = int'(irq_in) & ~m_irqq & MASK;
      take = cpu_ack && exp_irq() != 0;
      w    = lowest(m_pend & m_ien);
      np = m_pend; ni = m_isr; nie = m_ien; ng = m_gie;
      if (ic_write) begin
        case (int'(ic_addr[2:0]))
          0: np = np & ~wd;
          1: nie = wd;
          3: if (m_isr != 0) ni = ni & ~(1 << lowest(m_isr));
          4: ng = int'(ic_wdata[0]);
          default: ;
        endcase
      end
      if (take) begin
        np = np & ~(1 << w);
        ni = ni | (1 << w);
      end
      np = np | rise;
      nq = int'(irq_in);
    end
    @(posedge clk);
    #1;
    m_pend = np; m_isr = ni; m_ien = nie; m_gie = ng; m_irqq = nq; m_done = nd;
    check("cpu_irq", 48'(cpu_irq), 48'(exp_irq()));
    check("cpu_vec", 48'(cpu_vec), 48'(exp_vec()));
    check("ic_done", 48'(ic_done), 48'(m_done));
    check("ic_rdata", ic_rdata, m_read(int'(ic_addr[2:0])));
  endtask

  task automatic bus_write(input int a, input logic [47:0] d);
    ic_write = 1'b1; ic_addr = 15'(a); ic_wdata = d;
    tick();
    ic_write = 1'b0;
  endtask

  task automatic ack();
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
  endtask

  task automatic pulse(input int lines);
    irq_in = NIRQ'(lines);
    tick();
    irq_in = '0;
    tick();
  endtask

  // Directed check of one register against a constant.
  task automatic peek(input string tag, input int a, input logic [47:0] exp);
    ic_addr = 15'(a);
    #1;
    check(tag, ic_rdata, exp);
  endtask

  initial begin
    reset = 1'b1; irq_in = '0; cpu_ack = 1'b0; ic_addr = '0;
    ic_read = 1'b0; ic_write = 1'b0; ic_wdata = '0;
    tick(); tick();
    reset = 1'b0;
    peek("rst_pend", 0, 48'h0);
    check("rst_irq", 48'(cpu_irq), 48'h0);

    // 1. Basic request with a 2-cycle timer pulse.
    bus_write(1, 48'h01);
    bus_write(4, 48'h1);
    irq_in = 8'h01; tick(); tick(); irq_in = '0; tick();
    peek("t1_pend", 0, 48'h01);
    check("t1_irq", 48'(cpu_irq), 48'h1);
    check("t1_vec", 48'(cpu_vec), 48'h0);
    ack();
    peek("t1_pend_ack", 0, 48'h0);
    peek("t1_isr_ack", 2, 48'h01);
    check("t1_irq_ack", 48'(cpu_irq), 48'h0);
    bus_write(3, 48'h0);
    peek("t1_isr_eoi", 2, 48'h0);

    // 2. Priority between simultaneous sources.
    bus_write(1, 48'hFF);
    pulse(8'h24);
    check("t2_vec", 48'(cpu_vec), 48'h2);
    ack();
    check("t2_blocked", 48'(cpu_irq), 48'h0);
    bus_write(3, 48'h0);
    check("t2_irq5", 48'(cpu_irq), 48'h1);
    check("t2_vec5", 48'(cpu_vec), 48'h5);
    ack();
    bus_write(3, 48'h0);

    // 3. Nesting.
    pulse(8'h10);
    ack();
    peek("t3_isr10", 2, 48'h10);
    pulse(8'h02);
    check("t3_irq", 48'(cpu_irq), 48'h1);
    check("t3_vec", 48'(cpu_vec), 48'h1);
    ack();
    peek("t3_isr12", 2, 48'h12);
    bus_write(3, 48'h0);
    peek("t3_eoi1", 2, 48'h10);
    bus_write(3, 48'h0);
    peek("t3_eoi2", 2, 48'h0);
    bus_write(3, 48'h0);
    peek("t3_eoi_empty", 2, 48'h0);

    // 4. Masking.
    bus_write(1, 48'h00);
    pulse(8'h08);
    peek("t4_pend", 0, 48'h08);
    check("t4_masked", 48'(cpu_irq), 48'h0);
    bus_write(1, 48'h08);
    check("t4_unmasked", 48'(cpu_irq), 48'h1);
    bus_write(0, 48'h08);
    peek("t4_cleared", 0, 48'h0);
    check("t4_irq_off", 48'(cpu_irq), 48'h0);

    // 5. Collisions on PEND[6].
    bus_write(1, 48'h40);
    irq_in = 8'h40;
    bus_write(0, 48'h40);
    irq_in = '0; tick();
    peek("t5_rise_beats_w1c", 0, 48'h40);
    irq_in = 8'h40;
    ack();
    irq_in = '0;
    peek("t5_pend_rerise", 0, 48'h40);
    peek("t5_isr_rerise", 2, 48'h40);
    bus_write(0, 48'h40);
    bus_write(3, 48'h0);

    // 6. Bus read-back and reset mid-service.
    for (int a = 0; a < 8; a++) begin
      ic_read = 1'b1; ic_addr = 15'(a);
      tick();
      ic_read = 1'b0;
      tick();
    end
    peek("t6_addr6", 6, 48'h0);
    peek("t6_addr7", 7, 48'h0);
    peek("t6_eoi_reads0", 3, 48'h0);
    bus_write(1, 48'h04);
    pulse(8'h04);
    ack();
    pulse(8'h30);
    peek("t6_pre_isr", 2, 48'h04);
    peek("t6_pre_pend", 0, 48'h30);
    irq_in = 8'h01;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int a = 0; a < 8; a++) peek("t6_rst_reg", a, 48'h0);
    check("t6_rst_irq", 48'(cpu_irq), 48'h0);
    tick();
    peek("t6_held_line_one_rise", 0, 48'h01);
    tick();
    irq_in = '0;
    tick();
    peek("t6_held_line_no_retrigger", 0, 48'h01);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      irq_in   = NIRQ'($urandom & $urandom);
      cpu_ack  = ($urandom_range(0, 2) == 0);
      ic_write = ($urandom_range(0, 3) == 0);
      ic_read  = ($urandom_range(0, 3) == 0);
      ic_addr  = 15'($urandom);
      ic_wdata = {16'($urandom), 32'($urandom)};
      reset    = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1'b0; cpu_ack = 1'b0; ic_write = 1'b0; ic_read = 1'b0; irq_in = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
